rob_retire: RTL and testbench
=============================

# rob_retire

In-order reorder buffer and retire stage for the out-of-order RISC-V core. Rename allocates physical destination registers from the free pool; this block returns them. Each renamed instruction takes one entry at dispatch and is marked complete by the complete stage. The block then retires entries strictly in program order and emits the superseded physical register (`old_pd`) back to the free pool.

## Interface
Parameters:
- `DEPTH`, 16, number of ROB entries; power of two.
- `IDX_W`, 4, log2(DEPTH).
- `PREG_W`, 6, physical register index width (64 physical regs).
- `AREG_W`, 5, architectural register index width.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `alloc_valid` in 1: dispatch presents an instruction.
- `alloc_ready` out 1: ROB can accept; `count < DEPTH`.
- `alloc_rd` in AREG_W: architectural destination; 0 = no destination.
- `alloc_pd` in PREG_W: newly allocated physical destination.
- `alloc_old_pd` in PREG_W: previous RAT mapping of `alloc_rd`.
- `alloc_idx` out IDX_W: entry index the current alloc will occupy (= tail), combinational.
- `cmpl_valid` in 1: complete-stage writeback strobe.
- `cmpl_idx` in IDX_W: ROB index being completed.
- `ret0_valid`, `ret1_valid` out 1: oldest / second-oldest retirement this cycle.
- `ret0_rd`, `ret1_rd` out AREG_W: retired architectural destination.
- `ret0_pd`, `ret1_pd` out PREG_W: retired physical destination (now committed mapping).
- `free0_valid`, `free1_valid` out 1: release `freeN_pd` to free pool.
- `free0_pd`, `free1_pd` out PREG_W: physical register being freed (`old_pd`).
- `count` out IDX_W+1: occupied entries, 0..DEPTH.

## Operation
- Per entry: `busy`, `done`, `rd`, `pd`, `old_pd`. Pointers `head`, `tail` are IDX_W bits and wrap modulo DEPTH.
- Alloc: on an edge with `alloc_valid && alloc_ready`, write entry[tail] with `busy=1, done=0`, then `tail <= tail+1`. With `alloc_ready=0`, alloc is ignored and state is unchanged.
- Complete: on an edge with `cmpl_valid`, if entry[cmpl_idx].busy, set `done=1`. A non-busy index is ignored. Re-completing a done entry has no effect.
- Retire decision is made each edge from pre-edge state:
  - r0 = entry[head].busy && done.
  - r1 = r0 && entry[head+1].busy && done.
  - Retired entries clear `busy`/`done`; `head <= head + r0 + r1`.
- Retire outputs are registered. Slot N valid for exactly one cycle after the retiring edge, carrying that entry's fields.
- `freeN_valid = retN_valid && (rd != 0)`. Entries with rd=0 retire but free nothing. `freeN_pd` holds `old_pd` regardless.
- `count <= count + accepted_alloc − (r0 + r1)`. Simultaneous alloc and retire are both applied.
- Out-of-order completion is legal; retirement never skips a non-done head.

## Timing
- Reset (async assert, applies immediately):
  - all `busy`/`done` = 0; `head=tail=0`; `count=0`.
  - all `ret*`/`free*` outputs 0.
  - `alloc_ready=1`, `alloc_idx=0`.
- Alloc → entry visible to complete: the next edge after acceptance.
- Complete → retire: `cmpl_valid` sampled at edge E sets done. The entry retires at edge E+1 (if head). `retN_valid` is high in the cycle E+1..E+2.
- Steady state: 2 retirements/cycle maximum, 1 alloc/cycle.
- `alloc_ready` depends on pre-edge `count` only. A full ROB does not accept in the same cycle it retires; ready rises the cycle after.
- Pointer wrap: index 15 → 0; entries at 15 and 0 may retire together.
- Reset deasserted mid-operation: all in-flight entries are discarded. No `free*` pulses are emitted for them.

## Configuration
- `ROB_DUAL_RETIRE_EN` defined: two retire slots as above.
- Not defined: r1 forced 0, so at most one retirement per cycle. `ret1_*`/`free1_*` are tied to 0. All other behaviour is identical.

## Test plan
- Reset: assert `rst_n=0` mid-cycle → `count=0`, `alloc_ready=1`, `alloc_idx=0`, all ret/free valids 0 immediately.
- Alloc idx0 (rd=1, pd=32, old=1), idx1 (rd=2, pd=33, old=2), idx2 (rd=3, pd=34, old=3). Then:
  - complete 2, then 0 → idx0 retires alone, `ret0_pd=32`, `free0_pd=1`.
  - complete 1 → idx1 and idx2 retire on the same edge: `free0_pd=2`, `free1_pd=3`. Without the macro, they retire on consecutive cycles.
- Fill 16 entries → `alloc_ready=0`, `count=16`, 17th alloc ignored. Complete idx0 → after retire, `count=15`, and `alloc_ready=1` the following cycle.
- Rd=0 entry (old=9) completes → `ret0_valid=1`, `free0_valid=0`.
- 40 back-to-back alloc/complete/retire → `alloc_idx` wraps 15→0, the retire sequence matches program order, and `count` never exceeds 16.
- Reset with 5 busy entries (2 done) → no `free*` pulses, `count=0` after reset.

Source files
------------

// File: rtl/rob_retire.sv
// rtl/rob_retire.sv - in-order reorder buffer and retire stage returning superseded physical regs
// ROB_DUAL_RETIRE_EN enables the second retire slot; without it at most one entry retires per cycle.
module rob_retire #(
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4,
  parameter int PREG_W = 6,
  parameter int AREG_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  input  logic [AREG_W-1:0] alloc_rd,
  input  logic [PREG_W-1:0] alloc_pd,
  input  logic [PREG_W-1:0] alloc_old_pd,
  output logic [IDX_W-1:0]  alloc_idx,
  input  logic              cmpl_valid,
  input  logic [IDX_W-1:0]  cmpl_idx,
  output logic              ret0_valid,
  output logic              ret1_valid,
  output logic [AREG_W-1:0] ret0_rd,
  output logic [AREG_W-1:0] ret1_rd,
  output logic [PREG_W-1:0] ret0_pd,
  output logic [PREG_W-1:0] ret1_pd,
  output logic              free0_valid,
  output logic              free1_valid,
  output logic [PREG_W-1:0] free0_pd,
  output logic [PREG_W-1:0] free1_pd,
  output logic [IDX_W:0]    count
);

  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  done_q;
  logic [AREG_W-1:0] rd_q     [DEPTH];
  logic [PREG_W-1:0] pd_q     [DEPTH];
  logic [PREG_W-1:0] old_pd_q [DEPTH];
  logic [IDX_W-1:0]  head_q;
  logic [IDX_W-1:0]  tail_q;
  logic [IDX_W:0]    count_q;
  logic              alloc_fire;
  logic              r0;
  logic              r1;
  logic [IDX_W:0]    n_ret;

  assign alloc_ready = (count_q < (IDX_W+1)'(DEPTH));
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign alloc_idx   = tail_q;
  assign count       = count_q;

  assign r0 = busy_q[head_q] && done_q[head_q];
`ifdef ROB_DUAL_RETIRE_EN
  logic [IDX_W-1:0] head1;
  assign head1 = head_q + IDX_W'(1);
  assign r1    = r0 && busy_q[head1] && done_q[head1];
`else
  assign r1    = 1'b0;
`endif
  assign n_ret = (IDX_W+1)'(r0) + (IDX_W+1)'(r1);

  // Order matters: retire clears after complete, alloc writes last (tail is never a retiring entry).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (cmpl_valid && busy_q[cmpl_idx]) begin
        done_q[cmpl_idx] <= 1'b1;
      end
      if (r0) begin
        busy_q[head_q] <= 1'b0;
        done_q[head_q] <= 1'b0;
      end
`ifdef ROB_DUAL_RETIRE_EN
      if (r1) begin
        busy_q[head1] <= 1'b0;
        done_q[head1] <= 1'b0;
      end
`endif
      if (alloc_fire) begin
        busy_q[tail_q] <= 1'b1;
        done_q[tail_q] <= 1'b0;
        tail_q         <= tail_q + IDX_W'(1);
      end
      head_q  <= head_q + n_ret[IDX_W-1:0];
      count_q <= count_q + (IDX_W+1)'(alloc_fire) - n_ret;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      rd_q[tail_q]     <= alloc_rd;
      pd_q[tail_q]     <= alloc_pd;
      old_pd_q[tail_q] <= alloc_old_pd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ret0_valid  <= 1'b0;
      ret0_rd     <= '0;
      ret0_pd     <= '0;
      free0_valid <= 1'b0;
      free0_pd    <= '0;
    end else begin
      ret0_valid  <= r0;
      ret0_rd     <= r0 ? rd_q[head_q] : '0;
      ret0_pd     <= r0 ? pd_q[head_q] : '0;
      free0_valid <= r0 && (rd_q[head_q] != '0);
      free0_pd    <= r0 ? old_pd_q[head_q] : '0;
    end
  end

`ifdef ROB_DUAL_RETIRE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ret1_valid  <= 1'b0;
      ret1_rd     <= '0;
      ret1_pd     <= '0;
      free1_valid <= 1'b0;
      free1_pd    <= '0;
    end else begin
      ret1_valid  <= r1;
      ret1_rd     <= r1 ? rd_q[head1] : '0;
      ret1_pd     <= r1 ? pd_q[head1] : '0;
      free1_valid <= r1 && (rd_q[head1] != '0);
      free1_pd    <= r1 ? old_pd_q[head1] : '0;
    end
  end
`else
  assign ret1_valid  = 1'b0;
  assign ret1_rd     = '0;
  assign ret1_pd     = '0;
  assign free1_valid = 1'b0;
  assign free1_pd    = '0;
`endif

endmodule

// File: tb/tb_rob_retire.sv
// tb/tb_rob_retire.sv - directed self-checking bench for rob_retire
module tb_rob_retire;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       alloc_valid;
  logic       alloc_ready;
  logic [4:0] alloc_rd;
  logic [5:0] alloc_pd;
  logic [5:0] alloc_old_pd;
  logic [3:0] alloc_idx;
  logic       cmpl_valid;
  logic [3:0] cmpl_idx;
  logic       ret0_valid, ret1_valid;
  logic [4:0] ret0_rd, ret1_rd;
  logic [5:0] ret0_pd, ret1_pd;
  logic       free0_valid, free1_valid;
  logic [5:0] free0_pd, free1_pd;
  logic [4:0] count;

  int vectors = 0;
  int miscompares = 0;
  int max_count;
  logic [5:0] got[$];
  logic [3:0] base;
  logic flag;

  rob_retire #(.DEPTH(16), .IDX_W(4), .PREG_W(6), .AREG_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_rd(alloc_rd),
    .alloc_pd(alloc_pd), .alloc_old_pd(alloc_old_pd), .alloc_idx(alloc_idx),
    .cmpl_valid(cmpl_valid), .cmpl_idx(cmpl_idx),
    .ret0_valid(ret0_valid), .ret1_valid(ret1_valid),
    .ret0_rd(ret0_rd), .ret1_rd(ret1_rd), .ret0_pd(ret0_pd), .ret1_pd(ret1_pd),
    .free0_valid(free0_valid), .free1_valid(free1_valid),
    .free0_pd(free0_pd), .free1_pd(free1_pd), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_alloc(input logic [4:0] rd, input logic [5:0] pd, input logic [5:0] old);
    alloc_valid = 1'b1; alloc_rd = rd; alloc_pd = pd; alloc_old_pd = old;
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic do_cmpl(input logic [3:0] idx);
    cmpl_valid = 1'b1; cmpl_idx = idx;
    tick();
    cmpl_valid = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    alloc_valid = 0; alloc_rd = 0; alloc_pd = 0; alloc_old_pd = 0;
    cmpl_valid = 0; cmpl_idx = 0;
    rst_n = 1'b1;
    #12 rst_n = 1'b0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_ready", alloc_ready, 1);
    chk("rst_idx", alloc_idx, 0);
    chk("rst_ret0_valid", ret0_valid, 0);
    chk("rst_ret1_valid", ret1_valid, 0);
    chk("rst_free0_valid", free0_valid, 0);
    chk("rst_free1_valid", free1_valid, 0);
    chk("rst_free0_pd", free0_pd, 0);
    tick();
    rst_n = 1'b1;

    // three allocs, out-of-order completion
    do_alloc(5'd1, 6'd32, 6'd1);
    do_alloc(5'd2, 6'd33, 6'd2);
    do_alloc(5'd3, 6'd34, 6'd3);
    chk("alloc3_count", count, 3);
    chk("alloc3_idx", alloc_idx, 3);
    do_cmpl(4'd2);
    chk("head_not_done_no_ret", ret0_valid, 0);
    do_cmpl(4'd0);
    chk("ret_not_same_edge", ret0_valid, 0);
    tick();
    chk("r0_valid", ret0_valid, 1);
    chk("r0_rd", ret0_rd, 1);
    chk("r0_pd", ret0_pd, 32);
    chk("r0_free_valid", free0_valid, 1);
    chk("r0_free_pd", free0_pd, 1);
    chk("r0_ret1_valid", ret1_valid, 0);
    chk("r0_count", count, 2);
    do_cmpl(4'd1);
    chk("ret_one_cycle", ret0_valid, 0);
    tick();
`ifdef ROB_DUAL_RETIRE_EN
    chk("pair_ret0_pd", ret0_pd, 33);
    chk("pair_free0_pd", free0_pd, 2);
    chk("pair_ret1_valid", ret1_valid, 1);
    chk("pair_ret1_pd", ret1_pd, 34);
    chk("pair_free1_valid", free1_valid, 1);
    chk("pair_free1_pd", free1_pd, 3);
    chk("pair_count", count, 0);
`else
    chk("seq1_ret0_valid", ret0_valid, 1);
    chk("seq1_ret0_pd", ret0_pd, 33);
    chk("seq1_free0_pd", free0_pd, 2);
    chk("seq1_ret1_valid", ret1_valid, 0);
    chk("seq1_count", count, 1);
    tick();
    chk("seq2_ret0_valid", ret0_valid, 1);
    chk("seq2_ret0_pd", ret0_pd, 34);
    chk("seq2_free0_pd", free0_pd, 3);
    chk("seq2_count", count, 0);
`endif
    tick();
    chk("idle_ret0_valid", ret0_valid, 0);

    // full ROB
    do_reset();
    for (int i = 0; i < 16; i++) do_alloc(5'(i + 1), 6'(16 + i), 6'(i));
    chk("full_count", count, 16);
    chk("full_ready", alloc_ready, 0);
    chk("full_idx", alloc_idx, 0);
    alloc_valid = 1'b1; alloc_rd = 5'd7; alloc_pd = 6'd50; alloc_old_pd = 6'd7;
    cmpl_valid = 1'b1; cmpl_idx = 4'd0;
    tick();
    cmpl_valid = 1'b0;
    chk("full_alloc_ignored", count, 16);
    tick();
    chk("full_ret0_valid", ret0_valid, 1);
    chk("full_ret0_pd", ret0_pd, 16);
    chk("full_free0_pd", free0_pd, 0);
    chk("full_after_ret_count", count, 15);
    chk("full_ready_after_ret", alloc_ready, 1);
    tick();
    alloc_valid = 1'b0;
    chk("refill_count", count, 16);
    chk("refill_idx", alloc_idx, 1);

    // rd = 0 frees nothing
    do_reset();
    do_alloc(5'd0, 6'd40, 6'd9);
    do_cmpl(4'd0);
    tick();
    chk("rd0_ret_valid", ret0_valid, 1);
    chk("rd0_ret_rd", ret0_rd, 0);
    chk("rd0_free_valid", free0_valid, 0);
    chk("rd0_free_pd", free0_pd, 9);
    chk("rd0_count", count, 0);

    // 40 back-to-back
    max_count = 0;
    for (int i = 0; i < 40; i++) begin
      chk("wrap_alloc_idx", alloc_idx, 32'((1 + i) % 16));
      alloc_valid = 1'b1; alloc_rd = 5'(i % 31 + 1); alloc_pd = 6'(i); alloc_old_pd = 6'(i + 7);
      cmpl_valid = (i > 0); cmpl_idx = 4'(i);
      tick();
      if (ret0_valid) got.push_back(ret0_pd);
      if (ret1_valid) got.push_back(ret1_pd);
      if (int'(count) > max_count) max_count = int'(count);
    end
    alloc_valid = 1'b0; cmpl_valid = 1'b1; cmpl_idx = 4'(40);
    tick();
    cmpl_valid = 1'b0;
    if (ret0_valid) got.push_back(ret0_pd);
    if (ret1_valid) got.push_back(ret1_pd);
    repeat (4) begin
      tick();
      if (ret0_valid) got.push_back(ret0_pd);
      if (ret1_valid) got.push_back(ret1_pd);
    end
    chk("stream_retire_total", got.size(), 40);
    for (int k = 0; k < got.size(); k++) chk("stream_order", got[k], k);
    chk("stream_count_le16", (max_count <= 16), 1);
    chk("stream_drained", count, 0);

    // reset with in-flight entries
    base = alloc_idx;
    for (int j = 0; j < 5; j++) do_alloc(5'(j + 1), 6'(20 + j), 6'(j));
    do_cmpl(base + 4'd1);
    do_cmpl(base + 4'd2);
    chk("inflight_count", count, 5);
    chk("inflight_no_ret", ret0_valid, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_count", count, 0);
    chk("midrst_idx", alloc_idx, 0);
    chk("midrst_free0", free0_valid, 0);
    tick();
    rst_n = 1'b1;
    flag = 1'b0;
    repeat (4) begin
      tick();
      flag = flag | free0_valid | free1_valid | ret0_valid | ret1_valid;
    end
    chk("postrst_no_pulses", flag, 0);
    chk("postrst_count", count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
